rs_issue_queue: RTL

RS_ISSUE_QUEUE -- requirements
Module: rs_issue_queue

---
 rtl/rs_issue_queue_pkg.sv | 19 +
 rtl/rs_issue_queue_age_select.sv | 57 +++++
 rtl/rs_issue_queue.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_queue_pkg.sv
// Shared definitions for the reservation-station issue queue: null tag,
// operation-type constants and entry-state encoding.
package rs_issue_queue_pkg;

  localparam int TAG_NULL = 0;
  localparam int OP_W     = 6;

  localparam logic [5:0] OP_ALU    = 6'd0;
  localparam logic [5:0] OP_ALU_I  = 6'd1;
  localparam logic [5:0] OP_BRANCH = 6'd2;
  localparam logic [5:0] OP_JUMP   = 6'd3;
  localparam logic [5:0] OP_LUI    = 6'd4;

  typedef enum logic [0:0] {
    ENT_FREE = 1'b0,
    ENT_BUSY = 1'b1
  } ent_state_e;

endpackage

// File: rtl/rs_issue_queue_age_select.sv
// Oldest-first one-hot grant over an eligibility mask, tracked with a
// DEPTH x DEPTH age matrix (age_q[i][j] = entry i is older than entry j).
module rs_age_select #(
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [DEPTH-1:0] eligible_i,
  input  logic [DEPTH-1:0] insert_i,
  input  logic [DEPTH-1:0] free_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  // A newcomer is younger than everything present; its own row and a freed row are cleared.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (flush_i) begin
          age_d[i][j] = 1'b0;
        end else if (insert_i[i] || free_i[i]) begin
          age_d[i][j] = 1'b0;
        end else if (insert_i[j]) begin
          age_d[i][j] = 1'b1;
        end else begin
          age_d[i][j] = age_q[i][j];
        end
      end
    end
  end

  // Grant the eligible entry that no other eligible entry is older than.
  always_comb begin : grant_blk
    logic [DEPTH-1:0] older_s;
    for (int i = 0; i < DEPTH; i++) begin
      older_s = '0;
      for (int j = 0; j < DEPTH; j++) begin
        older_s[j] = age_q[j][i];
      end
      grant_o[i] = eligible_i[i] && ((older_s & eligible_i) == '0);
    end
  end

  // Age matrix register; frozen while the pipeline is paused.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (en_i) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue with CDB wakeup and oldest-first dispatch.
// Optional macro RS_WAKEUP_BYPASS_EN: entries woken by the CDB are eligible in the same cycle.
module rs_issue_queue
  import rs_issue_queue_pkg::*;
#(
  parameter int RS_DEPTH  = 16,
  parameter int TAG_W     = 5,
  parameter int CDB_PORTS = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          roll_back,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [5:0]                    issue_op,
  input  logic [31:0]                   issue_inst,
  input  logic [31:0]                   issue_pc,
  input  logic [31:0]                   issue_imm,
  input  logic [TAG_W-1:0]              issue_tag,
  input  logic [31:0]                   issue_vj,
  input  logic [31:0]                   issue_vk,
  input  logic [TAG_W-1:0]              issue_qj,
  input  logic [TAG_W-1:0]              issue_qk,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_PORTS*32-1:0]       cdb_value,
  output logic                          disp_valid,
  input  logic                          alu_ready,
  output logic [5:0]                    disp_op,
  output logic [31:0]                   disp_inst,
  output logic [31:0]                   disp_pc,
  output logic [31:0]                   disp_imm,
  output logic [31:0]                   disp_vj,
  output logic [31:0]                   disp_vk,
  output logic [TAG_W-1:0]              disp_tag,
  output logic [$clog2(RS_DEPTH):0]     occupancy
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int OCC_W = IDX_W + 1;

  typedef struct packed {
    logic [5:0]       op;
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
  } entry_t;

  // Returns {hit, value}; scanning downward lets the lowest channel win on equal tags.
  function automatic logic [32:0] cdb_lookup(input logic [TAG_W-1:0] q);
    logic [32:0] r;
    r = 33'd0;
    for (int c = CDB_PORTS - 1; c >= 0; c--) begin
      if (cdb_valid[c] && (q != TAG_W'(TAG_NULL)) && (cdb_tag[c*TAG_W +: TAG_W] == q)) begin
        r = {1'b1, cdb_value[c*32 +: 32]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  ent_state_e        state_q [RS_DEPTH];
  ent_state_e        state_d [RS_DEPTH];
  entry_t            ent_q   [RS_DEPTH];
  entry_t            ent_d   [RS_DEPTH];
  entry_t            ent_w_s [RS_DEPTH];
  entry_t            ins_ent_s;
  entry_t            disp_q, disp_d;
  logic              dvalid_q, dvalid_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [RS_DEPTH-1:0] elig_s, grant_s, ins_oh_s, free_oh_s;
  logic [IDX_W-1:0]  free_idx_s, sel_idx_s;
  logic              ins_en_s, load_en_s;

  assign issue_ready = (occ_q < OCC_W'(RS_DEPTH));
  assign ins_en_s    = issue_valid && issue_ready && rdy_in && !roll_back;
  assign load_en_s   = rdy_in && !roll_back && (!dvalid_q || alu_ready) && (|grant_s);
  assign ins_oh_s    = ins_en_s ? (RS_DEPTH'(1) << free_idx_s) : '0;
  assign free_oh_s   = load_en_s ? grant_s : '0;

  // CDB wakeup of stored entries and of the incoming instruction.
  always_comb begin : wake_blk
    logic [32:0] lk;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_w_s[i] = ent_q[i];
      lk = cdb_lookup(ent_q[i].qj);
      if (lk[32]) begin
        ent_w_s[i].vj = lk[31:0];
        ent_w_s[i].qj = TAG_W'(TAG_NULL);
      end else begin
        ent_w_s[i].qj = ent_q[i].qj;
      end
      lk = cdb_lookup(ent_q[i].qk);
      if (lk[32]) begin
        ent_w_s[i].vk = lk[31:0];
        ent_w_s[i].qk = TAG_W'(TAG_NULL);
      end else begin
        ent_w_s[i].qk = ent_q[i].qk;
      end
`ifdef RS_WAKEUP_BYPASS_EN
      elig_s[i] = (state_q[i] == ENT_BUSY) && (ent_w_s[i].qj == TAG_W'(TAG_NULL))
                  && (ent_w_s[i].qk == TAG_W'(TAG_NULL));
`else
      elig_s[i] = (state_q[i] == ENT_BUSY) && (ent_q[i].qj == TAG_W'(TAG_NULL))
                  && (ent_q[i].qk == TAG_W'(TAG_NULL));
`endif
    end
    ins_ent_s = '{op: issue_op, inst: issue_inst, pc: issue_pc, imm: issue_imm, tag: issue_tag,
                  vj: issue_vj, vk: issue_vk, qj: issue_qj, qk: issue_qk};
    lk = cdb_lookup(issue_qj);
    if (lk[32]) begin
      ins_ent_s.vj = lk[31:0];
      ins_ent_s.qj = TAG_W'(TAG_NULL);
    end else begin
      ins_ent_s.qj = issue_qj;
    end
    lk = cdb_lookup(issue_qk);
    if (lk[32]) begin
      ins_ent_s.vk = lk[31:0];
      ins_ent_s.qk = TAG_W'(TAG_NULL);
    end else begin
      ins_ent_s.qk = issue_qk;
    end
  end

  // Lowest free slot for insertion; grant is one-hot so its index is an OR of positions.
  always_comb begin
    free_idx_s = '0;
    sel_idx_s  = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      free_idx_s = (state_q[i] == ENT_FREE) ? IDX_W'(i) : free_idx_s;
      sel_idx_s  = sel_idx_s | (grant_s[i] ? IDX_W'(i) : IDX_W'(0));
    end
  end

  rs_age_select #(.DEPTH(RS_DEPTH)) u_age (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .en_i       (rdy_in),
    .flush_i    (roll_back),
    .eligible_i (elig_s),
    .insert_i   (ins_oh_s),
    .free_i     (free_oh_s),
    .grant_o    (grant_s)
  );

  // Next state: roll_back overrides insert and dispatch.
  always_comb begin
    ent_d    = ent_w_s;
    disp_d   = disp_q;
    dvalid_d = dvalid_q;
    occ_d    = occ_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (roll_back) begin
        state_d[i] = ENT_FREE;
      end else if (ins_oh_s[i]) begin
        state_d[i] = ENT_BUSY;
        ent_d[i]   = ins_ent_s;
      end else if (free_oh_s[i]) begin
        state_d[i] = ENT_FREE;
      end else begin
        state_d[i] = state_q[i];
      end
    end
    if (roll_back) begin
      dvalid_d = 1'b0;
      occ_d    = '0;
    end else begin
      occ_d = occ_q + OCC_W'(ins_en_s) - OCC_W'(load_en_s);
      if (load_en_s) begin
        disp_d   = ent_w_s[sel_idx_s];
        dvalid_d = 1'b1;
      end else if (alu_ready) begin
        dvalid_d = 1'b0;
      end else begin
        dvalid_d = dvalid_q;
      end
    end
  end

  // State registers; everything holds while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        state_q[i] <= ENT_FREE;
        ent_q[i]   <= '0;
      end
      disp_q   <= '0;
      dvalid_q <= 1'b0;
      occ_q    <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        state_q[i] <= state_d[i];
        ent_q[i]   <= ent_d[i];
      end
      disp_q   <= disp_d;
      dvalid_q <= dvalid_d;
      occ_q    <= occ_d;
    end
  end

  assign disp_valid = dvalid_q;
  assign disp_op    = disp_q.op;
  assign disp_inst  = disp_q.inst;
  assign disp_pc    = disp_q.pc;
  assign disp_imm   = disp_q.imm;
  assign disp_vj    = disp_q.vj;
  assign disp_vk    = disp_q.vk;
  assign disp_tag   = disp_q.tag;
  assign occupancy  = occ_q;

endmodule
